audio_i2s_deserializer: RTL and testbench
=========================================

AUDIO_I2S_DESERIALIZER -- requirements
Module: audio_i2s_deserializer

Interface
REQ-001 Parameter DATA_W, default 16, meaning: output sample width in bits (legal 8..32).
REQ-002 Parameter MODE, default 0, meaning: 0 = I2S (MSB one bck after lrck edge), 1 = left-justified (MSB on same bck as lrck edge).
REQ-003 Parameter SYNC_STAGES, default 2, meaning: synchronizer depth on bck/lrck/dat (legal 2..3).
REQ-004 clk  input  1  system clock; the only clock; must run at least 4x bck.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 bck  input  1  serial bit clock, asynchronous to clk, sampled as data.
REQ-007 lrck  input  1  word select, 0 = left, 1 = right.
REQ-008 dat  input  1  serial audio data, MSB first.
REQ-009 outl  output  DATA_W  left sample of the presented stereo pair.
REQ-010 outr  output  DATA_W  right sample of the presented stereo pair.
REQ-011 out_valid  output  1  pair on outl/outr is valid.
REQ-012 out_ready  input  1  consumer accepts the pair when high with out_valid.
REQ-013 overrun  output  1  sticky flag: a completed pair was dropped.

Function
REQ-014 bck, lrck and dat SHALL each pass through SYNC_STAGES flops in clk; bck_rise strobe = synchronized bck 0 then 1 on consecutive clk cycles.
REQ-015 All lrck/dat sampling SHALL occur only on bck_rise cycles.
REQ-016 Slot boundary SHALL be the bck_rise where sampled lrck differs from lrck sampled at the previous bck_rise.
REQ-017 MODE=0: the dat bit sampled on the boundary rise SHALL belong to the ending slot; MODE=1: it SHALL be MSB of the starting slot.
REQ-018 Per slot a bit counter SHALL run 0..DATA_W, saturating; bit n (n<DATA_W) SHALL be written to position DATA_W-1-n; bits with n>=DATA_W SHALL be discarded.
REQ-019 The slot shift register SHALL clear at slot start, so a short slot (<DATA_W bits) yields zero-padded LSBs.
REQ-020 Completed left word SHALL be held in a staging register; completion of the following right slot SHALL commit the pair {staged left, right}.
REQ-021 After reset, bits SHALL be ignored until the first left-slot start; a right slot without a preceding complete left slot SHALL NOT commit.
REQ-022 out_valid SHALL assert exactly 1 clk after the commit bck_rise cycle; outl/outr SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 out_valid SHALL deassert the clk after out_valid & out_ready, unless a commit occurs in that same cycle, in which case new pair loads and out_valid stays 1 with no overrun.
REQ-024 Commit while out_valid=1 and out_ready=0 SHALL drop the new pair, keep presented data, and set overrun=1 until reset.
REQ-025 Sustained bck_rise throughput SHALL be one bit per rise with no stall; no back-pressure on the serial side.

Reset
REQ-026 On reset: outl=0, outr=0, out_valid=0, overrun=0, counters/shift/staging registers=0, synchronizer flops=0, "first left seen" flag=0.
REQ-027 Reset asserted mid-slot SHALL abandon the partial frame; next output only after a full left+right following the next left-slot start.

Structure
REQ-028 A shared package audio_i2s_pkg SHALL hold MODE encodings (MODE_I2S=0, MODE_LJ=1) and a channel enum (CH_LEFT=0, CH_RIGHT=1).
REQ-029 One sub-module audio_sync_edge (SYNC_STAGES synchronizer + rise detector) SHALL be instantiated for bck, plain synchronizer instances for lrck/dat; all other logic in the top.

Verification
REQ-030 DATA_W=16, MODE=0, bck=clk/8, L=0xBF7F, R=0xCACA, out_ready=1 -> single out_valid pulse, outl=0xBF7F, outr=0xCACA, overrun=0.
REQ-031 MODE=0, right slot of 18 bits (two trailing junk 1s) after R=0xCACA -> outr=0xCACA.
REQ-032 DATA_W=24, 16-bit slots L=0x1234, R=0xABCD -> outl=0x123400, outr=0xABCD00.
REQ-033 out_ready=0 across two complete frames (0xBF7F/0xCACA then 0x1111/0x2222) -> outputs hold 0xBF7F/0xCACA, overrun=1; after out_ready=1, out_valid drops, no 0x1111 pair emitted.
REQ-034 MODE=1 with left-justified framing of L=0xBF7F, R=0xCACA -> outl=0xBF7F, outr=0xCACA.
REQ-035 reset pulsed mid-right-slot -> all outputs 0 next clk; first out_valid only after next complete left+right frame with correct values.

Source files
------------

// File: rtl/audio_i2s_pkg.sv
// audio_i2s_pkg: shared mode encodings and channel enum for the I2S receiver
package audio_i2s_pkg;
  localparam int MODE_I2S = 0;
  localparam int MODE_LJ = 1;
  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} ch_e;
endpackage

// File: rtl/audio_sync_edge.sv
// audio_sync_edge: multi-flop synchronizer with rise detect on sig and plain lanes on d
module audio_sync_edge #(
  parameter int STAGES = 2,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sig,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rise
);
  logic [W:0] sr [STAGES];
  logic last;
  // all lanes share one chain so lrck/dat stay aligned with bck
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) sr[i] <= '0;
      last <= 1'b0;
    end else begin
      sr[0] <= {d, sig};
      for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      last <= sr[STAGES-1][0];
    end
  end
  assign q = sr[STAGES-1][W:1];
  assign rise = sr[STAGES-1][0] & ~last;
endmodule

// File: rtl/audio_i2s_deserializer.sv
// audio_i2s_deserializer: I2S / left-justified serial audio to parallel stereo pairs
module audio_i2s_deserializer
  import audio_i2s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MODE = MODE_I2S,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bck,
  input  logic              lrck,
  input  logic              dat,
  output logic [DATA_W-1:0] outl,
  output logic [DATA_W-1:0] outr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_W);
  logic [1:0] ld;
  logic bck_rise, boundary, stage_l, commit, seen, lvalid;
  ch_e ch, lr_prev;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] sh, lstage, ins, word, msb;
  audio_sync_edge #(.STAGES(SYNC_STAGES), .W(2)) u_sync (
    .clk(clk),
    .reset(reset),
    .sig(bck),
    .d({dat, lrck}),
    .q(ld),
    .rise(bck_rise)
  );
  // bit placement and slot-boundary decode; in I2S the boundary bit is the LSB of the ending slot
  always_comb begin
    ch = ch_e'(ld[0]);
    msb = {ld[1], {(DATA_W-1){1'b0}}};
    ins = cnt < FULL ? msb >> cnt : '0;
    word = MODE == MODE_I2S ? sh | ins : sh;
    boundary = bck_rise && ch != lr_prev;
    stage_l = boundary && seen && lr_prev == CH_LEFT;
    commit = boundary && lvalid && lr_prev == CH_RIGHT;
  end
  // slot assembly: saturating bit counter, shift register, left staging
  always_ff @(posedge clk) begin
    if (reset) begin
      lr_prev <= CH_LEFT;
      cnt <= '0;
      sh <= '0;
      lstage <= '0;
      seen <= 1'b0;
      lvalid <= 1'b0;
    end else if (bck_rise) begin
      lr_prev <= ch;
      if (boundary) begin
        seen <= seen || ch == CH_LEFT;
        lvalid <= stage_l;
        cnt <= MODE == MODE_I2S ? '0 : CW'(1);
        sh <= MODE == MODE_I2S ? '0 : msb;
        if (stage_l) lstage <= word;
      end else begin
        sh <= sh | ins;
        cnt <= cnt < FULL ? cnt + CW'(1) : cnt;
      end
    end
  end
  // output pair register: a commit loads only when the slot is free or being drained
  always_ff @(posedge clk) begin
    if (reset) begin
      outl <= '0;
      outr <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (commit && (!out_valid || out_ready)) begin
      outl <= lstage;
      outr <= word;
      out_valid <= 1'b1;
    end else begin
      overrun <= overrun | commit;
      out_valid <= out_valid & ~out_ready;
    end
  end
endmodule

// File: tb/tb_audio_i2s_deserializer.sv
// tb_audio_i2s_deserializer: scoreboard bench over I2S-16, LJ-16 and I2S-24 instances
module tb_audio_i2s_deserializer;
  logic clk = 0, reset = 1, bck = 0, lrck = 0, dat_lj = 0, dat_i2s = 0, out_ready = 1, prev = 0;
  logic [15:0] l0, r0, l1, r1;
  logic [23:0] l2, r2;
  logic [2:0] v, ov;
  int passed = 0, total = 0;
  logic [63:0] q0[$], q1[$], q2[$];
  always #5 clk = ~clk;
  audio_i2s_deserializer #(.DATA_W(16), .MODE(0), .SYNC_STAGES(2)) u0 (
    .clk(clk), .reset(reset), .bck(bck), .lrck(lrck), .dat(dat_i2s),
    .outl(l0), .outr(r0), .out_valid(v[0]), .out_ready(out_ready), .overrun(ov[0]));
  audio_i2s_deserializer #(.DATA_W(16), .MODE(1), .SYNC_STAGES(3)) u1 (
    .clk(clk), .reset(reset), .bck(bck), .lrck(lrck), .dat(dat_lj),
    .outl(l1), .outr(r1), .out_valid(v[1]), .out_ready(out_ready), .overrun(ov[1]));
  audio_i2s_deserializer #(.DATA_W(24), .MODE(0), .SYNC_STAGES(2)) u2 (
    .clk(clk), .reset(reset), .bck(bck), .lrck(lrck), .dat(dat_i2s),
    .outl(l2), .outr(r2), .out_valid(v[2]), .out_ready(out_ready), .overrun(ov[2]));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] fit(input logic [31:0] val, input int n, input int w);
    logic [63:0] t;
    t = 64'(val) << (64 - n);
    return 32'(t >> (64 - w));
  endfunction
  task automatic take(input int i, input logic [63:0] got);
    if (i == 0 && q0.size() > 0) check("pair0", got, q0.pop_front());
    else if (i == 1 && q1.size() > 0) check("pair1", got, q1.pop_front());
    else if (i == 2 && q2.size() > 0) check("pair2", got, q2.pop_front());
    else check($sformatf("spurious%0d", i), 64'(v[i]), 64'(0));
  endtask
  // scoreboard pop on every accepted pair
  always @(negedge clk) begin
    if (!reset && out_ready) begin
      if (v[0]) take(0, {32'(l0), 32'(r0)});
      if (v[1]) take(1, {32'(l1), 32'(r1)});
      if (v[2]) take(2, {32'(l2), 32'(r2)});
    end
  end
  task automatic put(input logic lr, input logic b);
    bck = 0;
    lrck = lr;
    dat_lj = b;
    dat_i2s = prev;
    prev = b;
    repeat (4) @(negedge clk);
    bck = 1;
    repeat (4) @(negedge clk);
  endtask
  task automatic slot(input logic lr, input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) put(lr, val[i]);
  endtask
  task automatic frame(input logic [31:0] lv, input int nl, input logic [31:0] rv, input int nr, input bit exp_out);
    if (exp_out) begin
      q0.push_back({fit(lv, nl, 16), fit(rv, nr, 16)});
      q1.push_back({fit(lv, nl, 16), fit(rv, nr, 16)});
      q2.push_back({fit(lv, nl, 24), fit(rv, nr, 24)});
    end
    slot(1'b0, lv, nl);
    slot(1'b1, rv, nr);
  endtask
  task automatic set_ready(input logic b);
    @(posedge clk);
    #1 out_ready = b;
  endtask
  task automatic restart();
    reset = 1;
    prev = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    slot(1'b1, 32'h3, 2);
  endtask
  task automatic finish_stream(input string tag);
    slot(1'b0, 32'h0, 2);
    repeat (40) @(negedge clk);
    check(tag, 64'(q0.size() + q1.size() + q2.size()), 64'(0));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_v", 64'(v), 64'(0));
    check("rst_ov", 64'(ov), 64'(0));
    check("rst_l2", 64'(l2), 64'(0));
    check("rst_r0", 64'(r0), 64'(0));
    restart();
    frame(32'hBF7F, 16, 32'hCACA, 16, 1'b1);
    finish_stream("drain_basic");
    check("ov_basic", 64'(ov), 64'(0));
    restart();
    frame(32'hBF7F, 16, 32'h32B2B, 18, 1'b1);
    finish_stream("drain_long");
    restart();
    frame(32'h1234, 16, 32'hABCD, 16, 1'b1);
    frame(32'h5A5A, 16, 32'h00FF, 16, 1'b1);
    finish_stream("drain_b2b");
    restart();
    frame(32'hABC, 12, 32'h5, 4, 1'b1);
    finish_stream("drain_short");
    restart();
    set_ready(1'b0);
    frame(32'hBF7F, 16, 32'hCACA, 16, 1'b1);
    frame(32'h1111, 16, 32'h2222, 16, 1'b0);
    slot(1'b0, 32'h0, 2);
    repeat (40) @(negedge clk);
    check("ovr_v", 64'(v), 64'(3'b111));
    check("ovr_flag", 64'(ov), 64'(3'b111));
    check("ovr_hold_l0", 64'(l0), 64'(16'hBF7F));
    check("ovr_hold_r1", 64'(r1), 64'(16'hCACA));
    check("ovr_hold_r2", 64'(r2), 64'(24'hCACA00));
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check("ovr_drop_v", 64'(v), 64'(0));
    finish_stream("drain_ovr");
    check("ovr_sticky", 64'(ov), 64'(3'b111));
    restart();
    set_ready(1'b0);
    frame(32'hBF7F, 16, 32'hCACA, 16, 1'b0);
    slot(1'b0, 32'h1357, 16);
    check("pre_v", 64'(v), 64'(3'b111));
    check("pre_l1", 64'(l1), 64'(16'hBF7F));
    check("pre_r2", 64'(r2), 64'(24'hCACA00));
    slot(1'b1, 32'hA5, 8);
    reset = 1;
    @(negedge clk);
    check("mid_rst_v", 64'(v), 64'(0));
    check("mid_rst_l1", 64'(l1), 64'(0));
    check("mid_rst_r2", 64'(r2), 64'(0));
    reset = 0;
    set_ready(1'b1);
    slot(1'b1, 32'h5A, 8);
    frame(32'h2468, 16, 32'h1357, 16, 1'b1);
    finish_stream("drain_rst");
    check("rst_ov_clear", 64'(ov), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
